// File: rtl/dpram_fifo.sv
// dpram_fifo
//
// First-word-fall-through FIFO built on a one-write / one-combinational-read
// memory array. Gives a valid/ready buffer between a producer and a consumer.
//
// Parameters:
//   WIDTH        data word width in bits
//   DEPTH        number of entries (power of two, >= 2)
//   AFULL_THRESH almost_full asserts when count >= this value (1..DEPTH)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   wr_valid     producer offers wr_data
//   wr_ready     FIFO can accept a word (low while full or in reset)
//   wr_data      write data
//   rd_valid     head word present on rd_data
//   rd_ready     consumer takes the head word
//   rd_data      head word, forced to 0 when rd_valid is low
//   count        current occupancy, 0..DEPTH
//   almost_full  count >= AFULL_THRESH
//   flush        discard all contents (only when DPRAM_FIFO_FLUSH_EN is defined)
//
// Build option:
//   DPRAM_FIFO_FLUSH_EN  adds the flush port. Without it the FIFO behaves as
//                        if flush were tied low.

module dpram_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
`ifdef DPRAM_FIFO_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL   = CW'(AFULL_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;

    logic flush_req;
    logic full;
    logic push;
    logic pop;

`ifdef DPRAM_FIFO_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Full/empty come from the occupancy register, never from pointer
    // equality, so wp==rp is unambiguous.
    assign full = (count_q == CNT_DEPTH);

    // wr_ready looks only at our own state, keeping the read side out of the
    // write side's combinational path; a full FIFO refuses a push even in a
    // cycle that also pops.
    assign wr_ready = !full && !rst;

    // Outputs are held quiet during the reset cycle itself, before the
    // registers have actually cleared.
    assign rd_valid    = (count_q != '0) && !rst;
    assign almost_full = (count_q >= CNT_AFULL) && !rst;
    assign count       = count_q;

    // Stale memory is never exposed: data is gated by rd_valid.
    assign rd_data = rd_valid ? mem_q[rp_q] : '0;

    assign push = wr_valid && wr_ready;
    assign pop  = rd_valid && rd_ready;

    // Next-state for pointers and occupancy. Reset beats flush, flush beats
    // any push/pop in the same cycle.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (rst || flush_req) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + PTR_ONE;
            end
            if (pop) begin
                rp_d = rp_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        wp_q    <= wp_d;
        rp_q    <= rp_d;
        count_q <= count_d;
    end

    // Storage is intentionally not reset. A write during a flush cycle lands
    // in a slot that the cleared pointers immediately treat as free.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= wr_data;
        end
    end

endmodule
